instr_dispatch_fsm: RTL and testbench
=====================================

// Module: instr_dispatch_fsm
// PURPOSE
//  Initiator side of the execution-FSM start/done handshake. Accepts one instruction word per transaction.
//  Decodes the opcode and presents param1/param2 to the execution FSMs (MOV_FSM etc.).
//  Pulses the selected FSM_start bit for one cycle, waits for that FSM's done, then retires the instruction.
//  Sits between the instruction fetch stage and the bank of execution FSMs.
// PARAMETERS
//  OP_W        4    opcode width; instr_word[OP_W+2*PARAM_W-1 -: OP_W]
//  PARAM_W     6    operand width; param1 = instr_word[2*PARAM_W-1:PARAM_W], param2 = instr_word[PARAM_W-1:0]
//  NUM_FSM     8    number of execution FSMs; opcode k < NUM_FSM selects FSM k
//  CNT_W       16   retire counter width
//  WDOG_CYCLES 255  max WAIT cycles before timeout (only with DISPATCH_WATCHDOG_EN)
// PORTS
//  clock          in   1                 rising-edge clock
//  reset          in   1                 asynchronous, active-high reset
//  instr_valid    in   1                 instruction word valid
//  instr_word     in   OP_W+2*PARAM_W    {opcode, param1, param2}
//  instr_ready    out  1                 dispatcher can accept (high only in IDLE)
//  FSM_start      out  NUM_FSM           one-hot, single-cycle start pulse
//  param1         out  PARAM_W           latched operand 1, stable from START through RETIRE
//  param2         out  PARAM_W           latched operand 2, stable from START through RETIRE
//  fsm_done       in   NUM_FSM           done from each FSM (pulse or level)
//  busy           out  1                 high in every state except IDLE
//  instr_retired  out  1                 1-cycle pulse on successful completion
//  illegal_op     out  1                 1-cycle pulse when opcode >= NUM_FSM
//  timeout        out  1                 1-cycle pulse on watchdog expiry (tied 0 without macro)
//  retire_count   out  CNT_W             count of retired instructions
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, instr_ready=1; FSM_start, param1, param2, busy, pulses and retire_count = 0.
//    Reset mid-WAIT drops FSM_start/params at once; no retire is recorded.
//  States: IDLE, START, WAIT, RETIRE, ERR.
//  IDLE: on instr_valid, capture opcode/params (handshake: instr_valid & instr_ready).
//    opcode < NUM_FSM -> START. Otherwise -> ERR.
//  START (1 cycle): FSM_start[opcode]=1 and all other bits 0 -> WAIT. fsm_done is ignored in this state.
//  WAIT: sample only fsm_done[opcode]; other bits are ignored. On 1 -> RETIRE.
//    The first high sample completes the wait; a level done held after that has no further effect.
//  RETIRE (1 cycle): instr_retired=1, retire_count += 1 (wraps 2^CNT_W-1 -> 0) -> IDLE.
//  ERR (1 cycle): illegal_op=1, no FSM_start, retire_count unchanged -> IDLE.
//  Latency: accept at edge N; FSM_start high during cycle N+1.
//    done first seen at edge M -> instr_retired high during cycle M+1; instr_ready high again at cycle M+2.
//  instr_valid while busy: not accepted, no side effect. The upstream must hold the word until the handshake.
//  param1/param2 return to 0 on entry to IDLE.
// CONFIGURATION
//  DISPATCH_WATCHDOG_EN defined: a WAIT cycle counter (cleared on entering WAIT) runs.
//    On reaching WDOG_CYCLES without done: go to ERR-like 1-cycle state with timeout=1, illegal_op=0 -> IDLE; no retire.
//    done and expiry on the same cycle: done wins (RETIRE).
//  Not defined: no counter logic; timeout tied 0; WAIT waits indefinitely.
// TESTING
//  1 Reset, send 0x1042 (op1, p1=1, p2=2); done[1] 3 cycles after start
//    -> FSM_start=8'h02 for exactly 1 cycle, params 1/2 held, instr_retired once, retire_count=1.
//  2 Opcode 0xF word 0xF0C3 -> illegal_op 1-cycle pulse, FSM_start stays 0, retire_count unchanged, ready after 2 cycles.
//  3 During WAIT on op2, pulse fsm_done[5] and assert instr_valid
//    -> ignored, no accept; later done[2] -> retire.
//  4 Hold fsm_done[3] high continuously, send two op3 words
//    -> each retires exactly once, retire_count=2, no spurious start.
//  5 Assert reset in WAIT -> FSM_start/params/busy 0 immediately, retire_count=0, instr_ready=1 after release.
//  6 With DISPATCH_WATCHDOG_EN and WDOG_CYCLES=4, no done -> timeout pulse after 4 WAIT cycles, IDLE.
//    Without the macro -> still busy after 100 cycles.

Source files
------------

// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatcher: decodes one instruction word, pulses the selected execution FSM start, waits for its done.
// Optional watchdog on the WAIT state is enabled by defining DISPATCH_WATCHDOG_EN.
module instr_dispatch_fsm #(
  parameter int OP_W        = 4,
  parameter int PARAM_W     = 6,
  parameter int NUM_FSM     = 8,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic [OP_W+2*PARAM_W-1:0] instr_word,
  output logic                      instr_ready,
  output logic [NUM_FSM-1:0]        FSM_start,
  output logic [PARAM_W-1:0]        param1,
  output logic [PARAM_W-1:0]        param2,
  input  logic [NUM_FSM-1:0]        fsm_done,
  output logic                      busy,
  output logic                      instr_retired,
  output logic                      illegal_op,
  output logic                      timeout,
  output logic [CNT_W-1:0]          retire_count
);

  localparam int WORD_W = OP_W + 2*PARAM_W;
  localparam logic [OP_W:0] NUM_FSM_V = (OP_W+1)'(NUM_FSM);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    RETIRE = 3'd3,
    ERR    = 3'd4,
    TMO    = 3'd5
  } state_t;

  state_t             state_reg, state_next;
  logic [OP_W-1:0]    opcode_reg, opcode_next;
  logic [PARAM_W-1:0] param1_reg, param1_next;
  logic [PARAM_W-1:0] param2_reg, param2_next;
  logic [CNT_W-1:0]   retire_count_reg, retire_count_next;
  logic [NUM_FSM-1:0] sel_mask;
  logic               done_sel;
  logic               wdog_expired;

  logic [OP_W-1:0] word_op;
  assign word_op = instr_word[WORD_W-1 -: OP_W];

  // One-hot decode of the latched opcode, shared by start and done selection
  generate
    for (genvar gi = 0; gi < NUM_FSM; gi++) begin : g_sel
      assign sel_mask[gi]  = (opcode_reg == OP_W'(gi));
      assign FSM_start[gi] = (state_reg == START) && sel_mask[gi];
    end
  endgenerate

  assign done_sel = |(fsm_done & sel_mask);

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt_reg <= '0;
    end else if (state_reg == START) begin
      wdog_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end
  end

  assign wdog_expired = (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1));
  assign timeout      = (state_reg == TMO);
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES == 0);
  assign wdog_expired    = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      opcode_reg       <= '0;
      param1_reg       <= '0;
      param2_reg       <= '0;
      retire_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      opcode_reg       <= opcode_next;
      param1_reg       <= param1_next;
      param2_reg       <= param2_next;
      retire_count_reg <= retire_count_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    opcode_next       = opcode_reg;
    param1_next       = param1_reg;
    param2_next       = param2_reg;
    retire_count_next = retire_count_reg;
    case (state_reg)
      IDLE: begin
        if (instr_valid) begin
          opcode_next = word_op;
          param1_next = instr_word[2*PARAM_W-1:PARAM_W];
          param2_next = instr_word[PARAM_W-1:0];
          state_next  = ({1'b0, word_op} < NUM_FSM_V) ? START : ERR;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (done_sel)          state_next = RETIRE;
        else if (wdog_expired) state_next = TMO;
      end
      RETIRE: begin
        retire_count_next = retire_count_reg + 1'b1;
        param1_next       = '0;
        param2_next       = '0;
        state_next        = IDLE;
      end
      default: begin
        param1_next = '0;
        param2_next = '0;
        state_next  = IDLE;
      end
    endcase
  end

  assign instr_ready   = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign instr_retired = (state_reg == RETIRE);
  assign illegal_op    = (state_reg == ERR);
  assign param1        = param1_reg;
  assign param2        = param2_reg;
  assign retire_count  = retire_count_reg;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Directed bench for instr_dispatch_fsm: handshake, illegal opcode, done filtering, level done, reset and watchdog.
module tb_instr_dispatch_fsm;

`ifdef DISPATCH_WATCHDOG_EN
  localparam int TB_WDOG = 4;
`else
  localparam int TB_WDOG = 255;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_word = '0;
  logic        instr_ready;
  logic [7:0]  FSM_start;
  logic [5:0]  param1, param2;
  logic [7:0]  fsm_done = '0;
  logic        busy, instr_retired, illegal_op, timeout;
  logic [15:0] retire_count;

  int errors = 0;
  int checks = 0;
  int starts_seen, retires_seen;

  instr_dispatch_fsm #(
    .OP_W(4), .PARAM_W(6), .NUM_FSM(8), .CNT_W(16), .WDOG_CYCLES(TB_WDOG)
  ) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_word(instr_word),
    .instr_ready(instr_ready), .FSM_start(FSM_start), .param1(param1), .param2(param2),
    .fsm_done(fsm_done), .busy(busy), .instr_retired(instr_retired),
    .illegal_op(illegal_op), .timeout(timeout), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a word for one edge while in IDLE; returns in the cycle after the accept edge
  task automatic send(input logic [15:0] w);
    instr_valid = 1'b1;
    instr_word  = w;
    step(1);
    instr_valid = 1'b0;
    instr_word  = '0;
  endtask

  task automatic count_window(input int n);
    starts_seen  = 0;
    retires_seen = 0;
    for (int i = 0; i < n; i++) begin
      if (FSM_start != 8'h00) starts_seen++;
      if (instr_retired)      retires_seen++;
      step(1);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", FSM_start, 8'h00);
    check("rst_count", retire_count, 0);
    #10 reset = 1'b0;
    step(1);

    // 1: op1 p1=1 p2=2, done[1] a few cycles after start
    check("t1_ready", instr_ready, 1);
    send(16'h1042);
    check("t1_start", FSM_start, 8'h02);
    check("t1_p1", param1, 1);
    check("t1_p2", param2, 2);
    check("t1_busy", busy, 1);
    step(1);
    check("t1_start_once", FSM_start, 8'h00);
    check("t1_p1_wait", param1, 1);
    step(1);
    fsm_done = 8'h02;
    step(1);
    fsm_done = 8'h00;
    check("t1_retired", instr_retired, 1);
    check("t1_p2_retire", param2, 2);
    step(1);
    check("t1_retired_end", instr_retired, 0);
    check("t1_count", retire_count, 1);
    check("t1_ready_again", instr_ready, 1);
    check("t1_p1_clear", param1, 0);

    // 2: illegal opcode 0xF
    send(16'hF0C3);
    check("t2_illegal", illegal_op, 1);
    check("t2_start", FSM_start, 8'h00);
    check("t2_ready", instr_ready, 0);
    step(1);
    check("t2_illegal_end", illegal_op, 0);
    check("t2_ready_after", instr_ready, 1);
    check("t2_count", retire_count, 1);

    // 3: foreign done and new valid during WAIT are ignored
    send(16'h2145);
    check("t3_start", FSM_start, 8'h04);
    step(1);
    fsm_done    = 8'h20;
    instr_valid = 1'b1;
    instr_word  = 16'h1042;
    step(1);
    fsm_done = 8'h00;
    check("t3_busy", busy, 1);
    check("t3_no_retire", instr_retired, 0);
    check("t3_p1_kept", param1, 5);
    step(1);
    check("t3_not_accepted", instr_ready, 0);
    check("t3_no_start", FSM_start, 8'h00);
    instr_valid = 1'b0;
    instr_word  = '0;
    fsm_done    = 8'h04;
    step(1);
    fsm_done = 8'h00;
    check("t3_retired", instr_retired, 1);
    step(1);
    check("t3_count", retire_count, 2);

    // 4: level done held on fsm_done[3] across two instructions
    fsm_done = 8'h08;
    send(16'h30C1);
    check("t4a_start", FSM_start, 8'h08);
    count_window(6);
    check("t4a_starts", starts_seen, 1);
    check("t4a_retires", retires_seen, 1);
    send(16'h30C1);
    count_window(6);
    check("t4b_starts", starts_seen, 1);
    check("t4b_retires", retires_seen, 1);
    check("t4_count", retire_count, 4);
    fsm_done = 8'h00;

    // 5: reset asserted mid-WAIT acts immediately
    send(16'h1042);
    step(1);
    check("t5_busy_wait", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_start", FSM_start, 8'h00);
    check("t5_p1", param1, 0);
    check("t5_p2", param2, 0);
    check("t5_busy", busy, 0);
    check("t5_count", retire_count, 0);
    @(negedge clock);
    reset = 1'b0;
    step(1);
    check("t5_ready", instr_ready, 1);
    check("t5_no_retire", instr_retired, 0);

    // 6: watchdog
`ifdef DISPATCH_WATCHDOG_EN
    send(16'h1042);
    step(4);
    check("t6_no_timeout_yet", timeout, 0);
    check("t6_busy", busy, 1);
    step(1);
    check("t6_timeout", timeout, 1);
    check("t6_illegal", illegal_op, 0);
    check("t6_retired", instr_retired, 0);
    step(1);
    check("t6_timeout_end", timeout, 0);
    check("t6_ready", instr_ready, 1);
    check("t6_count", retire_count, 0);
`else
    send(16'h1042);
    step(100);
    check("t6_still_busy", busy, 1);
    check("t6_timeout_tied", timeout, 0);
    check("t6_not_ready", instr_ready, 0);
    fsm_done = 8'h02;
    step(1);
    fsm_done = 8'h00;
    check("t6_retired", instr_retired, 1);
    step(1);
    check("t6_count", retire_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
